// File: rtl/scratchpad_pkg.sv
// Shared types for the scratchpad controller.
//   - LEN_* : request size codes (0=1B, 1=2B, 2=4B, 3=8B)
//   - sp_req_t : queued request {wr, len, addr, wdata}
//   - sp_rsp_t : queued response {wr, err, rdata}
//   - len_bytes() : byte count for a size code
// The request address field is sized for the widest supported scratchpad;
// the controller zero-extends its ADDR_WIDTH-bit address into it.
package scratchpad_pkg;

  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_4B = 2'd2;
  localparam logic [1:0] LEN_8B = 2'd3;

  localparam int SP_ADDR_W_MAX = 32;

  typedef struct packed {
    logic                     wr;
    logic [1:0]               len;
    logic [SP_ADDR_W_MAX-1:0] addr;
    logic [63:0]              wdata;
  } sp_req_t;

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [63:0] rdata;
  } sp_rsp_t;

  function automatic logic [3:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_1B:  return 4'd1;
      LEN_2B:  return 4'd2;
      LEN_4B:  return 4'd4;
      LEN_8B:  return 4'd8;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/scratchpad_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst_n : clock, synchronous active-low reset (clears pointers/count)
//   push/wdata : write one entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   rdata      : current head entry (first-word fall-through)
//   count      : number of valid entries, 0..DEPTH
// DEPTH need not be a power of two; pointers wrap explicitly.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && (cnt != CW'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is data only; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/scratchpad_ctrl.sv
// scratchpad_ctrl: queues byte-addressed read/write requests, issues them
// one per cycle to a 64-bit registered-read scratchpad RAM, and returns one
// in-order response per request.
//   clk, rst_n                    : clock, synchronous active-low reset
//   req_valid/req_ready           : request handshake
//   req_wr, req_len, req_addr,
//   req_wdata                     : request type, size code, byte address, data
//   rsp_valid/rsp_ready           : response handshake
//   rsp_wr, rsp_err, rsp_rdata    : echoed type, bounds error, read data
//   ram_en, ram_wr, ram_len,
//   ram_addr, ram_wdata           : RAM command (combinational, issue cycle only)
//   ram_rdata                     : RAM read data, valid the cycle after a read
// ADDR_WIDTH must be below 32 (the package address field width).
module scratchpad_ctrl
  import scratchpad_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int REQ_DEPTH  = 4,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [1:0]            req_len,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic                  rsp_err,
  output logic [63:0]           rsp_rdata,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic [1:0]            ram_len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [63:0]           ram_wdata,
  input  logic [63:0]           ram_rdata
);

  localparam int QCW = $clog2(REQ_DEPTH + 1);
  localparam int RCW = $clog2(RSP_DEPTH + 1);

  sp_req_t               req_in;
  sp_req_t               head;
  logic [QCW-1:0]        req_count;
  logic                  req_push;
  logic                  issue;
  logic                  ram_go;
  logic                  head_err;
  logic [ADDR_WIDTH:0]   end_addr;

  sp_rsp_t               rsp_in;
  sp_rsp_t               rsp_head;
  logic [RCW-1:0]        rsp_count;
  logic [RCW:0]          rsp_occ;
  logic                  rsp_pop;

  logic                  inflight;
  logic                  wr_p1;
  logic                  err_p1;

  // Stage p0: accept into the request queue
  always_comb begin
    req_in       = '0;
    req_in.wr    = req_wr;
    req_in.len   = req_len;
    req_in.addr[ADDR_WIDTH-1:0] = req_addr;
    req_in.wdata = req_wdata;
  end

  assign req_ready = rst_n && (req_count != QCW'(REQ_DEPTH));
  assign req_push  = req_valid && req_ready;

  sync_fifo #(
    .WIDTH ($bits(sp_req_t)),
    .DEPTH (REQ_DEPTH),
    .CW    (QCW)
  ) u_req_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_push),
    .wdata (req_in),
    .pop   (issue),
    .rdata (head),
    .count (req_count)
  );

  // Stage p1: issue the head. The response queue must have room for every
  // outstanding item, counting a pop happening this very cycle.
  always_comb begin
    rsp_occ  = {1'b0, rsp_count} + (RCW+1)'(inflight) - (RCW+1)'(rsp_pop);
    issue    = rst_n && (req_count != '0) && (rsp_occ < (RCW+1)'(RSP_DEPTH));
    // One extra bit holds addr + size without wrapping; any set address bit
    // above ADDR_WIDTH is also out of range.
    end_addr = {1'b0, head.addr[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(len_bytes(head.len));
    head_err = (|head.addr[SP_ADDR_W_MAX-1:ADDR_WIDTH]) ||
               (end_addr > {1'b1, {ADDR_WIDTH{1'b0}}});
  end

  assign ram_go    = issue && !head_err;
  assign ram_en    = ram_go;
  assign ram_wr    = ram_go && head.wr;
  assign ram_len   = ram_go ? head.len : '0;
  assign ram_addr  = ram_go ? head.addr[ADDR_WIDTH-1:0] : '0;
  assign ram_wdata = ram_go ? head.wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= issue;
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      wr_p1  <= head.wr;
      err_p1 <= head_err;
    end
  end

  // Stage p2: capture RAM data and push the response
  always_comb begin
    rsp_in       = '0;
    rsp_in.wr    = wr_p1;
    rsp_in.err   = err_p1;
    rsp_in.rdata = (!wr_p1 && !err_p1) ? ram_rdata : 64'h0;
  end

  sync_fifo #(
    .WIDTH ($bits(sp_rsp_t)),
    .DEPTH (RSP_DEPTH),
    .CW    (RCW)
  ) u_rsp_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .wdata (rsp_in),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .count (rsp_count)
  );

  // Stage p3: present the response queue head
  assign rsp_valid = rst_n && (rsp_count != '0);
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_wr    = rsp_valid && rsp_head.wr;
  assign rsp_err   = rsp_valid && rsp_head.err;
  assign rsp_rdata = rsp_valid ? rsp_head.rdata : 64'h0;

endmodule

// File: tb/tb_scratchpad_ctrl.sv
module tb_scratchpad_ctrl;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [1:0]    req_len;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_wr;
  logic          rsp_err;
  logic [63:0]   rsp_rdata;
  logic          ram_en;
  logic          ram_wr;
  logic [1:0]    ram_len;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;

  scratchpad_ctrl #(.ADDR_WIDTH(AW), .REQ_DEPTH(4), .RSP_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_len   (req_len),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_len   (ram_len),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM: byte lanes, registered read, zero-extended sub-word data
  logic [7:0] mem [1024];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wr) begin
        for (int b = 0; b < (1 << ram_len); b++)
          mem[int'(ram_addr) + b] <= ram_wdata[8*b +: 8];
      end else begin
        logic [63:0] t;
        t = '0;
        for (int b = 0; b < (1 << ram_len); b++)
          t[8*b +: 8] = mem[int'(ram_addr) + b];
        ram_rdata <= t;
      end
    end
  end

  typedef struct {
    logic        wr;
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } rec_t;

  rec_t rsp_q[$];
  int   ram_q[$];

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_wr, rsp_err, rsp_rdata, cyc});
    if (ram_en) ram_q.push_back(cyc);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0101;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rsp_q.delete();
    ram_q.delete();
  endtask

  task automatic send(input logic wr, input logic [1:0] len, input int addr, input logic [63:0] wd);
    logic ok;
    int   guard;
    req_valid = 1'b1;
    req_wr    = wr;
    req_len   = len;
    req_addr  = AW'(addr);
    req_wdata = wd;
    guard     = 0;
    do begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 50);
    chk("send_accept", 64'(ok), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int guard;
    guard = 0;
    while (rsp_q.size() < n && guard < 200) begin
      tick(1);
      guard++;
    end
    chk(tag, 64'(rsp_q.size()), 64'(n));
  endtask

  task automatic chk_rsp(input string tag, input int i, input logic wr, input logic err,
                         input logic [63:0] rd);
    if (i < rsp_q.size()) begin
      chk({tag, "_wr"}, 64'(rsp_q[i].wr), 64'(wr));
      chk({tag, "_err"}, 64'(rsp_q[i].err), 64'(err));
      chk({tag, "_rdata"}, rsp_q[i].rdata, rd);
    end else begin
      chk({tag, "_missing"}, 64'(rsp_q.size()), 64'(i + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int k;
    logic ok;

    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_len   = 2'd3;
    req_addr  = '0;
    req_wdata = 64'h1234;
    rsp_ready = 1'b1;

    // Reset held with a pending request
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_ram_en", 64'(ram_en), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b1;
    tick(2);

    // 8B write then 8B read, back-to-back, minimum latency
    clear_logs();
    b = cyc;
    send(1'b1, 2'd3, 16, 64'h0123456789ABCDEF);
    send(1'b0, 2'd3, 16, 64'h0);
    wait_rsp("wr8_rsp_count", 2);
    chk("wr8_ram_pulses", 64'(ram_q.size()), 64'd2);
    if (ram_q.size() >= 2) begin
      chk("wr8_issue_cyc0", 64'(ram_q[0] - b), 64'd1);
      chk("wr8_issue_cyc1", 64'(ram_q[1] - b), 64'd2);
    end
    chk_rsp("wr8_r0", 0, 1'b1, 1'b0, 64'h0);
    chk_rsp("wr8_r1", 1, 1'b0, 1'b0, 64'h0123456789ABCDEF);
    if (rsp_q.size() >= 2) begin
      chk("wr8_rsp_cyc0", 64'(rsp_q[0].cyc - b), 64'd3);
      chk("wr8_rsp_cyc1", 64'(rsp_q[1].cyc - b), 64'd4);
    end

    // Sub-word read returns only the requested lanes
    clear_logs();
    send(1'b1, 2'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    send(1'b0, 2'd1, 0, 64'h0);
    wait_rsp("sub_rsp_count", 2);
    chk_rsp("sub_r1", 1, 1'b0, 1'b0, 64'h0000_0000_0000_FFFF);

    // 8B read at 1020 crosses the top: errored, never reaches the RAM
    tick(2);
    clear_logs();
    send(1'b0, 2'd3, 1020, 64'h0);
    wait_rsp("oob_rsp_count", 1);
    tick(2);
    chk("oob_ram_pulses", 64'(ram_q.size()), 64'd0);
    chk_rsp("oob_r0", 0, 1'b0, 1'b1, 64'h0);

    // 4B at 1020 ends exactly at the top: in bounds
    clear_logs();
    send(1'b1, 2'd2, 1020, 64'h0000_0000_DEAD_BEEF);
    send(1'b0, 2'd2, 1020, 64'h0);
    wait_rsp("edge_rsp_count", 2);
    chk("edge_ram_pulses", 64'(ram_q.size()), 64'd2);
    chk_rsp("edge_r0", 0, 1'b1, 1'b0, 64'h0);
    chk_rsp("edge_r1", 1, 1'b0, 1'b0, 64'h0000_0000_DEAD_BEEF);

    // Preload eight words for the ordering test
    for (int i = 0; i < 8; i++) send(1'b1, 2'd3, 64 + 8*i, pat(i));
    wait_rsp("pre_rsp_count", 8);
    tick(2);

    // Backpressure: 8 reads with rsp_ready low, release after 12 cycles
    clear_logs();
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 12) begin
        chk("bp_accepts", 64'(k), 64'd6);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
        chk("bp_hold_rdata", rsp_rdata, pat(0));
        rsp_ready = 1'b1;
      end
      req_valid = (k < 8);
      req_wr    = 1'b0;
      req_len   = 2'd3;
      req_addr  = AW'(64 + 8*k);
      req_wdata = 64'h0;
      @(negedge clk);
      ok = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (ok) k++;
    end
    req_valid = 1'b0;
    chk("bp_total_accepts", 64'(k), 64'd8);
    wait_rsp("bp_rsp_count", 8);
    for (int i = 0; i < 8; i++) begin
      chk_rsp($sformatf("bp_r%0d", i), i, 1'b0, 1'b0, pat(i));
      if (i < rsp_q.size()) chk($sformatf("bp_rate%0d", i), 64'(rsp_q[i].cyc - rsp_q[0].cyc), 64'(i));
    end

    // Reset with work queued and in flight discards everything
    rsp_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++) send(1'b0, 2'd3, 64 + 8*i, 64'h0);
    tick(3);
    chk("mid_rsp_pending", 64'(rsp_valid), 64'd1);
    clear_logs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_ram_en", 64'(ram_en), 64'd0);
    chk("mid_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    tick(15);
    chk("mid_no_ram", 64'(ram_q.size()), 64'd0);
    chk("mid_no_rsp", 64'(rsp_q.size()), 64'd0);
    send(1'b0, 2'd3, 64 + 8*3, 64'h0);
    wait_rsp("mid_new_count", 1);
    chk_rsp("mid_new_r0", 0, 1'b0, 1'b0, pat(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
